// File: rtl/pwm_steer_sched.sv
// pwm_steer_sched: steering command scheduler in front of pwm_dir.
// Arbitrates planner (A) and override (B) commands with B taking strict
// priority. Each accepted command is clamped to the servo-safe window.
// cmd_out is slewed toward the target at most once per PWM frame.
// A frame-based watchdog returns steering to CENTER when commands stop arriving.
module pwm_steer_sched #(
    parameter int FRAME_LEN      = 607,
    parameter int CENTER         = 150,
    parameter int MIN_CMD        = 115,
    parameter int MAX_CMD        = 185,
    parameter int STEP           = 4,
    parameter int TIMEOUT_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       req_a_valid,
    input  logic [7:0] req_a_data,
    output logic       req_a_ready,
    input  logic       req_b_valid,
    input  logic [7:0] req_b_data,
    output logic       req_b_ready,
    output logic [7:0] cmd_out,
    output logic       frame_tick,
    output logic       grant_b,
    output logic       busy,
    output logic       failsafe
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int WD_W  = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [7:0]       C_CENTER = 8'(CENTER);
    localparam logic [7:0]       C_MIN    = 8'(MIN_CMD);
    localparam logic [7:0]       C_MAX    = 8'(MAX_CMD);
    localparam logic [7:0]       C_STEP   = 8'(STEP);
    localparam logic signed [8:0] C_STEP_S = 9'(STEP);
    localparam logic [WD_W-1:0]  C_TO     = WD_W'(TIMEOUT_FRAMES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [7:0]       r_cmd;
    logic [7:0]       r_target;
    logic [WD_W-1:0]  r_wd;
    logic             r_fs;
    logic             r_grant_b;
    logic             r_busy;

    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_acc_a;
    logic             w_acc_b;
    logic [7:0]       w_tgt_nx;
    logic [7:0]       w_cmd_nx;
    logic [WD_W-1:0]  w_wd_nx;
    logic             w_fs_nx;
    logic             w_gb_nx;
    logic             w_busy_nx;

    // Limit a raw command to the servo-safe window.
    function automatic logic [7:0] f_clamp(input logic [7:0] d);
        if (d < C_MIN)
            return C_MIN;
        else if (d > C_MAX)
            return C_MAX;
        else
            return d;
    endfunction

    // Move cur toward tgt by at most STEP. The 9-bit signed difference
    // cannot overflow for 8-bit unsigned operands.
    function automatic logic [7:0] f_slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic signed [8:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > C_STEP_S)
            return cur + C_STEP;
        else if (diff < -C_STEP_S)
            return cur - C_STEP;
        else
            return tgt;
    endfunction

    // Ready outputs are held low while reset is asserted.
    assign req_b_ready = enable & rst;
    assign req_a_ready = enable & rst & ~req_b_valid;

    assign cmd_out    = r_cmd;
    assign frame_tick = r_tick;
    assign grant_b    = r_grant_b;
    assign busy       = r_busy;
    assign failsafe   = r_fs;

    // Next-state logic: arbitration, target/watchdog update, per-frame slew.
    always_comb begin
        w_cnt_nx = (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
        w_acc_b  = enable & req_b_valid;
        w_acc_a  = enable & ~req_b_valid & req_a_valid;
        w_tgt_nx = r_target;
        w_wd_nx  = r_wd;
        w_fs_nx  = r_fs;
        w_gb_nx  = r_grant_b;
        if (!enable) begin
            w_tgt_nx = C_CENTER;
            w_wd_nx  = '0;
            w_fs_nx  = 1'b0;
        end else if (w_acc_b || w_acc_a) begin
            // An accept outranks a watchdog expiry landing in the same cycle.
            w_tgt_nx = f_clamp(w_acc_b ? req_b_data : req_a_data);
            w_gb_nx  = w_acc_b;
            w_wd_nx  = '0;
            w_fs_nx  = 1'b0;
        end else if (r_tick && (r_wd != C_TO)) begin
            w_wd_nx = r_wd + WD_W'(1);
            if (r_wd == C_TO - WD_W'(1)) begin
                w_fs_nx  = 1'b1;
                w_tgt_nx = C_CENTER;
            end
        end
        // The slew reads the registered target, so a target accepted in the
        // tick cycle takes effect from the following frame.
        w_cmd_nx  = r_tick ? f_slew(r_cmd, r_target) : r_cmd;
        w_busy_nx = (w_cmd_nx != w_tgt_nx);
    end

    // State registers; frame_tick is high in the cycle where the counter is FRAME_LEN-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_cmd     <= C_CENTER;
            r_target  <= C_CENTER;
            r_wd      <= '0;
            r_fs      <= 1'b0;
            r_grant_b <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_tick    <= (w_cnt_nx == C_LAST);
            r_cmd     <= w_cmd_nx;
            r_target  <= w_tgt_nx;
            r_wd      <= w_wd_nx;
            r_fs      <= w_fs_nx;
            r_grant_b <= w_gb_nx;
            r_busy    <= w_busy_nx;
        end
    end

endmodule
